mdu_param: RTL and testbench

- Parametrised successor to the pipeline's fixed 32-bit multiply/divide unit; sits in E stage beside the ALU.
- Configurable operand width and per-operation latency; adds signed-overflow and divide-by-zero rules, MTHI/MTLO gating while busy, and an optional cancel.
- HCU stalls D-stage MDU instructions on (start | busy).
- `out` feeds the E-stage MDU/ALU result mux.

---
 rtl/mdu_param.sv | 149 ++++++++++++++
 tb/tb_mdu_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_param.sv
// Parametrised E-stage multiply/divide unit with HI/LO registers and fixed per-operation latency.
// Optional MDU_CANCEL_EN adds a `cancel` input that aborts an in-flight operation.
module mdu_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             cancel_i;

`ifdef MDU_CANCEL_EN
    assign cancel_i = cancel;
`else
    assign cancel_i = 1'b0;
`endif

    // Datapath on the latched operands; products are formed at full 2*WIDTH precision.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   mag_a, mag_b, div_sb, div_ub;
    logic [WIDTH-1:0]   sq_mag, sr_mag, s_quot, s_rem, u_quot, u_rem;

    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide via magnitudes; -2^(W-1) / -1 wraps back to -2^(W-1) with zero remainder.
    assign mag_a  = a_q[WIDTH-1] ? -a_q : a_q;
    assign mag_b  = b_q[WIDTH-1] ? -b_q : b_q;
    assign div_sb = (mag_b == '0) ? WIDTH'(1) : mag_b;
    assign div_ub = (b_q == '0) ? WIDTH'(1) : b_q;
    assign sq_mag = mag_a / div_sb;
    assign sr_mag = mag_a % div_sb;
    assign s_quot = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -sq_mag : sq_mag;
    assign s_rem  = a_q[WIDTH-1] ? -sr_mag : sr_mag;
    assign u_quot = a_q / div_ub;
    assign u_rem  = a_q % div_ub;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start && (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) && !cancel_i) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                    state_d = S_BUSY;
                end else if (op == OP_MTHI) begin
                    hi_d = a;
                end else if (op == OP_MTLO) begin
                    lo_d = a;
                end
            end
            S_BUSY: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV:   if (b_q != '0) {hi_d, lo_d} = {s_rem, s_quot};
                        OP_DIVU:  if (b_q != '0) {hi_d, lo_d} = {u_rem, u_quot};
                        default:  ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: all state, including the latched operands, is cleared so a reset discards any partial result.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        case (op)
            OP_MFHI: out = hi_q;
            OP_MFLO: out = lo_q;
            default: out = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_param.sv
// Directed bench for mdu_param (WIDTH=32): scoreboard of expected {hi,lo} checked when busy falls.
// Define MDU_CANCEL_EN for both files to exercise the cancel input.
module tb_mdu_param;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             busy;
    logic [WIDTH-1:0] hi, lo, out;
`ifdef MDU_CANCEL_EN
    logic             cancel;
`endif

    mdu_param #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
`ifdef MDU_CANCEL_EN
        .cancel(cancel),
`endif
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .out   (out)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model written with native 32/64-bit arithmetic; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
        int q, r;
        case (o)
            MULT:  return longint'($signed(x)) * longint'($signed(y));
            MULTU: return {32'b0, x} * {32'b0, y};
            DIV: begin
                if (y == 32'd0) return {h, l};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            DIVU: begin
                if (y == 32'd0) return {h, l};
                return {x % y, x / y};
            end
            default: return {h, l};
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(model(o, x, y, m_hi, m_lo));
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0; a = '0; b = '0;
    endtask

    // Counts remaining busy cycles (bounded), then pops and compares the committed result.
    task automatic wait_done(input string tag, input int lat, input int pre);
        int          cnt;
        logic [63:0] exp;
        cnt = pre;
        while (busy && cnt < 200) begin
            cnt++;
            @(posedge clk); #1;
        end
        check({tag, " busy_len"}, 64'(cnt), 64'(lat));
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
            check({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
    endtask

    task automatic move_to(input logic [3:0] o, input logic [31:0] x);
        @(negedge clk);
        op = o; a = x;
        @(posedge clk); #1;
        op = 4'd0; a = '0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset out", 64'(out), 64'd0);
        @(negedge clk) reset = 1'b1;

        // MULT -2 * 3, then read back through out.
        issue(MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done("mult_neg", MUL_LAT, 0);
        @(negedge clk) op = MFLO;
        #1 check("mflo out", 64'(out), 64'hFFFF_FFFA);
        op = MFHI;
        #1 check("mfhi out", 64'(out), 64'hFFFF_FFFF);
        op = 4'd0;

        issue(DIVU, 32'd100, 32'd7);
        wait_done("divu_100_7", DIV_LAT, 0);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", DIV_LAT, 0);

        // Divide by zero leaves HI/LO untouched.
        move_to(MTHI, 32'h1234); m_hi = 32'h1234;
        move_to(MTLO, 32'h0);    m_lo = 32'h0;
        check("mthi idle", 64'(hi), 64'h1234);
        issue(DIV, 32'd5, 32'd0);
        wait_done("div_by_zero", DIV_LAT, 0);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_overflow", DIV_LAT, 0);

        // MTLO and a second start while busy must both be dropped.
        issue(MULT, 32'd123, 32'd456);
        @(negedge clk); op = MTLO; a = 32'hAAAA;
        @(posedge clk); #1; op = 4'd0; a = '0;
        @(negedge clk); start = 1'b1; op = DIVU; a = 32'd9; b = 32'd3;
        @(posedge clk); #1; start = 1'b0; op = 4'd0; a = '0; b = '0;
        wait_done("mult_busy_ignores", MUL_LAT, 2);

        move_to(MTLO, 32'hAAAA); m_lo = 32'hAAAA;
        check("mtlo idle", 64'(lo), 64'hAAAA);

        for (int i = 0; i < 6; i++) begin
            logic [3:0]  o;
            logic [31:0] x, y;
            o = 4'($urandom_range(1, 4));
            x = $urandom;
            y = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            issue(o, x, y);
            wait_done($sformatf("rand%0d_op%0d", i, o), (o <= MULTU) ? MUL_LAT : DIV_LAT, 0);
        end

        // Asynchronous reset on busy cycle 4 of a DIV discards the operation.
        move_to(MTHI, 32'h77); m_hi = 32'h77;
        issue(DIV, 32'd50, 32'd5);
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        check("async_rst busy", 64'(busy), 64'd0);
        check("async_rst hi", 64'(hi), 64'd0);
        check("async_rst lo", 64'(lo), 64'd0);
        sb.delete(); m_hi = '0; m_lo = '0;
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst busy", 64'(busy), 64'd0);
        check("post_rst hi", 64'(hi), 64'd0);
        check("post_rst lo", 64'(lo), 64'd0);

`ifdef MDU_CANCEL_EN
        move_to(MTHI, 32'h55); m_hi = 32'h55;
        issue(MULT, 32'd6, 32'd7);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk) cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0;
        void'(sb.pop_back());
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel hi", 64'(hi), 64'h55);
        check("cancel lo", 64'(lo), 64'd0);
        @(negedge clk); start = 1'b1; op = MULT; a = 32'd2; b = 32'd2; cancel = 1'b1;
        @(posedge clk); #1; start = 1'b0; op = 4'd0; a = '0; b = '0; cancel = 1'b0;
        check("cancel start busy", 64'(busy), 64'd0);
        issue(MULT, 32'd6, 32'd7);
        wait_done("reissue_6x7", MUL_LAT, 0);
`endif

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
